// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : request/response sequencer for an external 4-bit combinational ALU.
//
// A request (opcode + two operands) is accepted in IDLE and held on the ALU
// drive outputs. The ALU is given EXEC_CYCLES cycles to settle, then its
// result is captured into the response registers and offered until the
// consumer takes it.
//
// Parameters
//   EXEC_CYCLES   ALU settle cycles before result capture (legal 1..15)
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid / req_ready           request handshake
//   req_op[2:0], req_x, req_y       request opcode and operands
//   alu_select, alu_in_c,
//   alu_in_x, alu_in_y              drive to the downstream ALU (registered)
//   alu_out_s, alu_out_c,
//   alu_zero, alu_overflow          results returned by the ALU
//   rsp_valid / rsp_ready           response handshake
//   rsp_s, rsp_c, rsp_zero, rsp_ovf registered result
//
// Build option
//   ALU_SEQ_STICKY_OVF_EN  adds sticky_clr (in) and sticky_ovf (out): a flag
//                          set by any captured overflow, cleared by sticky_clr
//                          (a capture with overflow wins over a clear).
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  // request
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  // ALU drive
  output logic [2:0] alu_select,
  output logic       alu_in_c,
  output logic [3:0] alu_in_x,
  output logic [3:0] alu_in_y,
  // ALU results
  input  logic [3:0] alu_out_s,
  input  logic       alu_out_c,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  // response
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_s,
  output logic       rsp_c,
  output logic       rsp_zero,
  output logic       rsp_ovf
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  input  logic       sticky_clr,
  output logic       sticky_ovf
`endif
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 4;

  // Counter reload: the capture happens on the edge where the counter is 0,
  // so loading N-1 gives exactly N edges from acceptance to rsp_valid.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_release;
  logic                w_cin;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;

  logic [OP_W-1:0]     r_op;
  logic                r_cin;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;

  logic [DATA_W-1:0]   r_rsp_s;
  logic                r_rsp_c;
  logic                r_rsp_zero;
  logic                r_rsp_ovf;

  // Carry-in is set for the subtract/compare opcodes (001, 110, 111).
  always_comb begin
    w_cin = 1'b0;
    unique case (req_op)
      3'b001, 3'b110, 3'b111: w_cin = 1'b1;
      default:                w_cin = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transition strobes. Acceptance is gated by the registered
  // ready so that nothing is taken while req_ready is still low after reset.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next state, so both read 0
  // while reset is asserted and follow the state one-for-one afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == DONE);
    end
  end

  // Settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Operand registers: loaded only on acceptance, held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_cin <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_op  <= req_op;
      r_cin <= w_cin;
      r_x   <= req_x;
      r_y   <= req_y;
    end
  end

  // Response registers: the ALU outputs are sampled on the capture edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_s    <= '0;
      r_rsp_c    <= 1'b0;
      r_rsp_zero <= 1'b0;
      r_rsp_ovf  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_s    <= alu_out_s;
      r_rsp_c    <= alu_out_c;
      r_rsp_zero <= alu_zero;
      r_rsp_ovf  <= alu_overflow;
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic r_sticky_ovf;

  // Sticky overflow: a captured overflow takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
    end else if (w_capture && alu_overflow) begin
      r_sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      r_sticky_ovf <= 1'b0;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
`endif

  // Output drive.
  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign alu_select = r_op;
  assign alu_in_c   = r_cin;
  assign alu_in_x   = r_x;
  assign alu_in_y   = r_y;
  assign rsp_s      = r_rsp_s;
  assign rsp_c      = r_rsp_c;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;

  // w_release only documents the DONE->IDLE transition; the state register
  // already encodes it.
  logic w_unused;
  assign w_unused = w_release;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, meaning ALU settle cycles before result capture; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have ports req_valid  input  1 and req_ready  output  1  request handshake.
REQ-005 The block SHALL have ports req_op  input  3, req_x  input  4 and req_y  input  4  request opcode and operands.
REQ-006 The block SHALL have ports alu_select  output  3, alu_in_c  output  1, alu_in_x  output  4 and alu_in_y  output  4  drive to the downstream 4-bit ALU.
REQ-007 The block SHALL have ports alu_out_s  input  4, alu_out_c  input  1, alu_zero  input  1 and alu_overflow  input  1  ALU results.
REQ-008 The block SHALL have ports rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-009 The block SHALL have ports rsp_s  output  4, rsp_c  output  1, rsp_zero  output  1 and rsp_ovf  output  1  registered result.

Function
REQ-010 The FSM SHALL have states IDLE, EXEC and DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-011 IDLE with req_valid=1 at an edge SHALL register req_op/req_x/req_y, load the counter with EXEC_CYCLES-1 and enter EXEC.
REQ-012 alu_select, alu_in_x and alu_in_y SHALL be driven from the operand registers and held stable from acceptance until the next acceptance.
REQ-013 alu_in_c SHALL be 1 for opcodes 001, 110 and 111, and 0 for all other opcodes (subtract/compare mode).
REQ-014 In EXEC the counter SHALL decrement each cycle; at the edge where counter=0 the FSM SHALL copy alu_out_s/alu_out_c/alu_zero/alu_overflow into rsp_* and enter DONE.
REQ-015 Latency: rsp_valid SHALL rise exactly EXEC_CYCLES edges after the acceptance edge.
REQ-016 In DONE rsp_* SHALL be held stable while rsp_ready=0; rsp_valid=1 with rsp_ready=1 at an edge SHALL return the FSM to IDLE.
REQ-017 A request presented in EXEC or DONE SHALL NOT be accepted; throughput is one request per EXEC_CYCLES+2 cycles with rsp_ready held high.
REQ-018 ALU inputs SHALL be sampled only at the capture edge; changes to ALU inputs in other cycles SHALL have no effect on rsp_*.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, counter 0, and all operand and rsp_* registers to 0, without waiting for clk.
REQ-020 During reset: req_ready=0, rsp_valid=0, and alu_* outputs SHALL be 0.
REQ-021 After rst_n deasserts: req_ready=1 and no response pending.
REQ-022 Reset during EXEC or DONE SHALL discard the operation; no response for it SHALL appear after reset.

Configuration
REQ-023 With ALU_SEQ_STICKY_OVF_EN defined, the block SHALL add ports sticky_clr  input  1 and sticky_ovf  output  1.
REQ-024 With ALU_SEQ_STICKY_OVF_EN defined, sticky_ovf SHALL set at a capture edge with alu_overflow=1, SHALL clear on an edge with sticky_clr=1, and SHALL set when both occur in the same cycle.
REQ-025 With ALU_SEQ_STICKY_OVF_EN defined, sticky_ovf SHALL reset to 0.
REQ-026 Without ALU_SEQ_STICKY_OVF_EN, the ports and register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Add: op=000, x=3, y=4, EXEC_CYCLES=1 -> alu_in_c=0; rsp_valid 1 edge after accept; rsp_s=7, rsp_c=0, rsp_zero=0, rsp_ovf=0.
REQ-028 Subtract: op=001, x=5, y=5 -> alu_in_c=1; rsp_s=0, rsp_zero=1, rsp_c=1, rsp_ovf=0.
REQ-029 Overflow and sticky: op=000, x=7, y=1 -> rsp_s=8, rsp_ovf=1, sticky_ovf=1; a following 3+4 request keeps sticky_ovf=1; pulsing sticky_clr clears it.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_* constant, req_ready=0, a req_valid pulse is ignored; rsp_ready=1 -> IDLE next edge.
REQ-031 Reset abort: EXEC_CYCLES=4; assert rst_n=0 two cycles after accept -> rsp_valid stays 0, all outputs 0 asynchronously, req_ready=1 after release.
REQ-032 Less-than: op=110, x=2, y=5 -> alu_in_c=1; rsp_s=0001 as returned by the ALU; latency matches REQ-015 for EXEC_CYCLES=3.
